jacobi_sweep_scheduler: RTL and testbench

Sequences the cyclic Jacobi eigenvalue iteration by stepping the rotation datapath through every off-diagonal pivot pair (row, col), row < col, in row-major cyclic order. For each pair it re-initialises the Givens rotation matrix, hands the pair to the rotation datapath over a valid/ready handshake and waits for completion. Sweeps repeat until a full sweep sees every pivot below tolerance, or until a sweep limit is reached. It sits between the top-level host control and the angle/Givens/matrix-update datapath.

---
 rtl/jacobi_sweep_scheduler.sv | 121 ++++++++++++
 tb/tb_jacobi_sweep_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jacobi_sweep_scheduler.sv
// Cyclic Jacobi sweep scheduler: walks every off-diagonal pivot pair (row<col) in
// row-major order, handshakes each to the rotation datapath, repeats sweeps until converged.
module jacobi_sweep_scheduler #(
  parameter int N          = 32,
  parameter int IDX_W      = 6,
  parameter int MAX_SWEEPS = 16,
  parameter int SW_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             converged,
  output logic [SW_W-1:0]  sweep_cnt,
  output logic             g_init,
  output logic             rot_valid,
  input  logic             rot_ready,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  input  logic             rot_done,
  input  logic             pivot_small
);

  typedef enum logic [2:0] {IDLE, INIT, ISSUE, WAIT, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(N - 2);
  localparam logic [SW_W-1:0]  SW_LIMIT = SW_W'(MAX_SWEEPS);

  state_t          state;
  logic            all_small;
  logic            small_next;
  logic [SW_W-1:0] sweep_next;

  always_comb begin
    small_next = all_small & pivot_small;
    sweep_next = sweep_cnt + SW_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      converged <= 1'b0;
      sweep_cnt <= '0;
      g_init    <= 1'b0;
      rot_valid <= 1'b0;
      row       <= '0;
      col       <= '0;
      all_small <= 1'b1;
    end else begin
      g_init <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            row       <= '0;
            col       <= IDX_W'(1);
            sweep_cnt <= '0;
            all_small <= 1'b1;
            converged <= 1'b0;
            busy      <= 1'b1;
            g_init    <= 1'b1;
            state     <= INIT;
          end
        end
        INIT: begin
          rot_valid <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: begin
          if (rot_ready) begin
            rot_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (rot_done) begin
            all_small <= small_next;
            if (col < LAST_COL) begin
              col    <= col + IDX_W'(1);
              g_init <= 1'b1;
              state  <= INIT;
            end else if (row < LAST_ROW) begin
              row    <= row + IDX_W'(1);
              col    <= row + IDX_W'(2);
              g_init <= 1'b1;
              state  <= INIT;
            end else begin
              // Sweep end: the flag includes the pivot finishing right now.
              sweep_cnt <= sweep_next;
              if (small_next) begin
                converged <= 1'b1;
                done      <= 1'b1;
                state     <= DONE;
              end else if (sweep_next == SW_LIMIT) begin
                converged <= 1'b0;
                done      <= 1'b1;
                state     <= DONE;
              end else begin
                row       <= '0;
                col       <= IDX_W'(1);
                all_small <= 1'b1;
                g_init    <= 1'b1;
                state     <= INIT;
              end
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jacobi_sweep_scheduler.sv
// Randomized bench for jacobi_sweep_scheduler (N=4, MAX_SWEEPS=3) against a pair-list /
// sweep-count reference model with a random-latency datapath responder.
module tb_jacobi_sweep_scheduler;
  localparam int N = 4, IDX_W = 3, MAX_SWEEPS = 3, SW_W = 3;
  localparam int NP = N * (N - 1) / 2;

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, rot_ready = 1'b0, rot_done = 1'b0, pivot_small = 1'b0;
  logic busy, done, converged, g_init, rot_valid;
  logic [SW_W-1:0]  sweep_cnt;
  logic [IDX_W-1:0] row, col;

  int checks = 0, errors = 0;
  int pair_r[$], pair_c[$];

  jacobi_sweep_scheduler #(.N(N), .IDX_W(IDX_W), .MAX_SWEEPS(MAX_SWEEPS), .SW_W(SW_W)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .converged(converged), .sweep_cnt(sweep_cnt), .g_init(g_init),
    .rot_valid(rot_valid), .rot_ready(rot_ready), .row(row), .col(col),
    .rot_done(rot_done), .pivot_small(pivot_small));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit pick_small(input int mode, input int sw);
    case (mode)
      0: return 1'b1;
      1: return sw >= 1;
      2: return 1'b0;
      default: return ($urandom_range(5) != 0);
    endcase
  endfunction

  // Drives one decomposition, checking the issued pair order, handshake stability and
  // done timing against the model. abort_sweep >= 0 raises reset while WAITing in that sweep.
  task automatic run_sequence(input int mode, input bit bp, input bit noise, input int abort_sweep,
                              output int n_xfer, output int n_ginit, output int n_done,
                              output bit aborted);
    int k = 0, sw = 0, wait_cnt = -1;
    bit all = 1'b1, exp_conv = 1'b0, exp_done_next = 1'b0, fin = 1'b0;
    bit prev_valid = 1'b0, prev_ready = 1'b0;
    logic [IDX_W-1:0] prev_row = '0, prev_col = '0;
    n_xfer = 0; n_ginit = 0; n_done = 0; aborted = 1'b0;
    start = 1'b1;
    for (int cyc = 0; cyc < 3000 && !fin && !aborted; cyc++) begin
      tick();
      if (prev_valid && prev_ready) begin
        checks++;
        if (k >= NP || row === 'x) begin
          errors++; $display("FAIL xfer_index got %0d limit %0d", k, NP);
        end else if (prev_row !== IDX_W'(pair_r[k]) || prev_col !== IDX_W'(pair_c[k])) begin
          errors++;
          $display("FAIL pair_order got (%0d,%0d) exp (%0d,%0d)", prev_row, prev_col, pair_r[k], pair_c[k]);
        end
        n_xfer++;
        wait_cnt = bp ? $urandom_range(2) : 0;
        checks++;
        if (rot_valid !== 1'b0) begin errors++; $display("FAIL valid_drop got %0b exp 0", rot_valid); end
      end
      if (prev_valid && !prev_ready) begin
        checks++;
        if (rot_valid !== 1'b1 || row !== prev_row || col !== prev_col) begin
          errors++;
          $display("FAIL hold_pair got v=%0b (%0d,%0d) exp v=1 (%0d,%0d)", rot_valid, row, col, prev_row, prev_col);
        end
      end
      if (g_init === 1'b1) n_ginit++;
      checks++;
      if (done !== exp_done_next) begin
        errors++; $display("FAIL done_timing got %0b exp %0b", done, exp_done_next);
      end
      if (done === 1'b1) n_done++;
      fin = exp_done_next;
      checks++;
      if (busy !== 1'b1 || sweep_cnt !== SW_W'(sw) || converged !== exp_conv) begin
        errors++;
        $display("FAIL run_status got busy=%0b sw=%0d conv=%0b exp busy=1 sw=%0d conv=%0b",
                 busy, sweep_cnt, converged, sw, exp_conv);
      end
      exp_done_next = 1'b0;
      if (fin) break;
      start = noise ? 1'($urandom_range(1)) : 1'b0;
      if (abort_sweep >= 0 && sw == abort_sweep && wait_cnt >= 0) begin
        reset = 1'b1; rot_done = 1'b0; rot_ready = 1'b0; start = 1'b0;
        aborted = 1'b1;
        break;
      end
      rot_ready = bp ? 1'($urandom_range(3) != 0) : 1'b1;
      if (!rot_valid && noise) rot_ready = 1'($urandom_range(1));
      rot_done = 1'b0;
      pivot_small = 1'($urandom_range(1));
      if (wait_cnt == 0) begin
        rot_done = 1'b1;
        pivot_small = pick_small(mode, sw);
        all = all & pivot_small;
        k++;
        wait_cnt = -1;
        if (k == NP) begin
          k = 0; sw++;
          if (all) begin exp_done_next = 1'b1; exp_conv = 1'b1; end
          else if (sw == MAX_SWEEPS) exp_done_next = 1'b1;
          else all = 1'b1;
        end
      end else if (wait_cnt > 0) begin
        wait_cnt--;
      end else if (noise && (rot_valid || g_init) && $urandom_range(2) == 0) begin
        rot_done = 1'b1;
        pivot_small = 1'b0;
      end
      prev_valid = rot_valid; prev_ready = rot_ready;
      prev_row = row; prev_col = col;
    end
    start = 1'b0; rot_done = 1'b0; rot_ready = 1'b0;
    if (!fin && !aborted) begin
      checks++; errors++;
      $display("FAIL timeout got no done exp done");
    end
    if (fin) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || sweep_cnt !== SW_W'(sw) || converged !== exp_conv) begin
        errors++;
        $display("FAIL after_done got done=%0b busy=%0b sw=%0d conv=%0b exp done=0 busy=0 sw=%0d conv=%0b",
                 done, busy, sweep_cnt, converged, sw, exp_conv);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if ({busy, done, converged, g_init, rot_valid} !== 5'b0 || sweep_cnt !== '0 || row !== '0 || col !== '0) begin
      errors++;
      $display("FAIL reset_state got b=%0b d=%0b c=%0b g=%0b v=%0b sw=%0d r=%0d c=%0d exp all 0",
               busy, done, converged, g_init, rot_valid, sweep_cnt, row, col);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_start_timing();
    start = 1'b1; rot_ready = 1'b1;
    tick(); start = 1'b0;
    checks++;
    if (g_init !== 1'b1 || busy !== 1'b1 || rot_valid !== 1'b0) begin
      errors++; $display("FAIL init_cycle got g=%0b b=%0b v=%0b exp g=1 b=1 v=0", g_init, busy, rot_valid);
    end
    tick();
    checks++;
    if (g_init !== 1'b0 || rot_valid !== 1'b1 || row !== '0 || col !== IDX_W'(1)) begin
      errors++; $display("FAIL issue_cycle got g=%0b v=%0b (%0d,%0d) exp g=0 v=1 (0,1)", g_init, rot_valid, row, col);
    end
    rot_ready = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0; tick();
  endtask

  task automatic test_converge_first();
    int nx, ng, nd; bit ab;
    run_sequence(0, 1'b0, 1'b0, -1, nx, ng, nd, ab);
    checks++;
    if (nx != 6 || ng != 6 || nd != 1 || converged !== 1'b1 || sweep_cnt !== SW_W'(1)) begin
      errors++;
      $display("FAIL converge_first got x=%0d g=%0d d=%0d c=%0b sw=%0d exp x=6 g=6 d=1 c=1 sw=1",
               nx, ng, nd, converged, sweep_cnt);
    end
  endtask

  task automatic test_converge_second();
    int nx, ng, nd; bit ab;
    run_sequence(1, 1'b0, 1'b0, -1, nx, ng, nd, ab);
    checks++;
    if (nx != 12 || ng != 12 || nd != 1 || converged !== 1'b1 || sweep_cnt !== SW_W'(2)) begin
      errors++;
      $display("FAIL converge_second got x=%0d g=%0d d=%0d c=%0b sw=%0d exp x=12 g=12 d=1 c=1 sw=2",
               nx, ng, nd, converged, sweep_cnt);
    end
  endtask

  task automatic test_sweep_limit();
    int nx, ng, nd; bit ab;
    run_sequence(2, 1'b0, 1'b0, -1, nx, ng, nd, ab);
    checks++;
    if (nx != 18 || ng != 18 || nd != 1 || converged !== 1'b0 || sweep_cnt !== SW_W'(3)) begin
      errors++;
      $display("FAIL sweep_limit got x=%0d g=%0d d=%0d c=%0b sw=%0d exp x=18 g=18 d=1 c=0 sw=3",
               nx, ng, nd, converged, sweep_cnt);
    end
  endtask

  task automatic test_backpressure_noise();
    int nx, ng, nd; bit ab;
    for (int m = 0; m < 4; m++) begin
      run_sequence(m, 1'b1, 1'b1, -1, nx, ng, nd, ab);
      checks++;
      if (nd != 1 || nx != ng || nx % NP != 0) begin
        errors++; $display("FAIL noisy_run mode=%0d got x=%0d g=%0d d=%0d exp d=1 x=g=k*%0d", m, nx, ng, nd, NP);
      end
    end
  endtask

  task automatic test_idle_ignore();
    logic [IDX_W-1:0] r0, c0; logic [SW_W-1:0] s0; logic cv0;
    r0 = row; c0 = col; s0 = sweep_cnt; cv0 = converged;
    for (int i = 0; i < 4; i++) begin
      rot_done = 1'b1; rot_ready = 1'b1; pivot_small = 1'($urandom_range(1));
      tick();
      checks++;
      if (busy !== 1'b0 || g_init !== 1'b0 || rot_valid !== 1'b0 || done !== 1'b0 ||
          row !== r0 || col !== c0 || sweep_cnt !== s0 || converged !== cv0) begin
        errors++;
        $display("FAIL idle_hold got b=%0b (%0d,%0d) sw=%0d c=%0b exp b=0 (%0d,%0d) sw=%0d c=%0b",
                 busy, row, col, sweep_cnt, converged, r0, c0, s0, cv0);
      end
    end
    rot_done = 1'b0; rot_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    int nx, ng, nd; bit ab;
    run_sequence(1, 1'b1, 1'b0, 1, nx, ng, nd, ab);
    checks++;
    if (!ab) begin errors++; $display("FAIL abort_reach got %0b exp 1", ab); end
    tick();
    checks++;
    if ({busy, done, converged, g_init, rot_valid} !== 5'b0 || sweep_cnt !== '0 || row !== '0 || col !== '0) begin
      errors++;
      $display("FAIL abort_state got b=%0b d=%0b c=%0b g=%0b v=%0b sw=%0d (%0d,%0d) exp all 0",
               busy, done, converged, g_init, rot_valid, sweep_cnt, row, col);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_no_done got d=%0b b=%0b exp 0 0", done, busy);
    end
    run_sequence(0, 1'b0, 1'b0, -1, nx, ng, nd, ab);
    checks++;
    if (nx != 6 || nd != 1 || sweep_cnt !== SW_W'(1) || converged !== 1'b1) begin
      errors++; $display("FAIL fresh_run got x=%0d d=%0d sw=%0d c=%0b exp 6 1 1 1", nx, nd, sweep_cnt, converged);
    end
  endtask

  initial begin
    for (int p = 0; p < N - 1; p++)
      for (int q = p + 1; q < N; q++) begin
        pair_r.push_back(p);
        pair_c.push_back(q);
      end
    test_reset();
    test_start_timing();
    test_converge_first();
    test_converge_second();
    test_sweep_limit();
    test_idle_ignore();
    test_backpressure_noise();
    test_idle_ignore();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
